// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM states and the PC alignment helper.
package instruction_fetch_unit_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] ILLEGAL_FETCH_WORD = 32'h0000_0000;
    localparam logic [XLEN-1:0]    PC_STEP            = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Instructions are word aligned; low address bits are simply dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect / increment / hold selection.
// Redirect targets are forced to word alignment before being loaded.
module fetch_pc_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0001_3880
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = align_pc(redirect_pc);
        end else if (advance) begin
            pc_next = pc + PC_STEP;
        end
    end

    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the ROM address, registers fetched words into the
// IF/ID stage, follows execute redirects and halts on an all-zero word.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0001_3880,
    parameter int              COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    input  logic               id_ready,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               halted,
    output logic               misaligned,
    output logic [COUNT_W-1:0] fetch_count
);

    fetch_state_e    state, state_next;
    logic            load;
    logic            zero_word;
    logic            advance;
    logic            handshake;
    logic [XLEN-1:0] pc;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .advance    (advance),
        .pc         (pc)
    );

    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign handshake = if_valid && id_ready;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = (state == RUN) && (!if_valid || id_ready);
        zero_word  = (imem_instr == ILLEGAL_FETCH_WORD);
        advance    = load && !zero_word;
        if (redirect) begin
            state_next = RUN;
        end else if (load && zero_word) begin
            state_next = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A load always implies the current occupant drains, so a zero word
    // leaves the stage empty rather than issuing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else begin
            misaligned  <= redirect && (|redirect_pc[1:0]);
            fetch_count <= fetch_count + COUNT_W'(handshake);
            if (redirect) begin
                if_valid <= 1'b0;
            end else if (load) begin
                if_valid <= !zero_word;
                if (!zero_word) begin
                    if_instr <= imem_instr;
                    if_pc    <= pc;
                end
            end else if (handshake) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a small ROM and a
// transaction-level reference model driven by directed and random steps.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state (architectural view of the stage).
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_halted;
    logic        m_mis;
    logic [31:0] m_count;

    instruction_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted),
        .misaligned (misaligned),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0001_3880: return 32'h002B_1513;
            32'h0001_3884: return 32'h0195_0533;
            32'h0001_3888: return 32'h0003_4483;
            32'h0001_388C: return 32'h00A0_0593;
            32'h0001_3890: return 32'h00B5_0533;
            32'h0001_3894: return 32'hFE00_06E3;
            32'hFFFF_FFFC: return 32'h0000_0013;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    assign imem_instr = rom(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0001_3880; m_valid = 0; m_instr = 0; m_ipc = 0;
        m_halted = 0; m_mis = 0; m_count = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"},   imem_addr,          m_pc);
        check({tag, ".if_valid"},    {31'b0, if_valid},  {31'b0, m_valid});
        check({tag, ".if_instr"},    if_instr,           m_instr);
        check({tag, ".if_pc"},       if_pc,              m_ipc);
        check({tag, ".halted"},      {31'b0, halted},    {31'b0, m_halted});
        check({tag, ".misaligned"},  {31'b0, misaligned},{31'b0, m_mis});
        check({tag, ".fetch_count"}, fetch_count,        m_count);
    endtask

    // Advance one clock: model the edge from current inputs, then compare
    // on the following falling edge.
    task automatic tick(input string tag);
        logic [31:0] n_pc, n_instr, n_ipc, n_count, w;
        logic        n_valid, n_halted, n_mis, took;
        took    = m_valid && id_ready;
        n_count = m_count + (took ? 32'd1 : 32'd0);
        n_pc = m_pc; n_valid = m_valid; n_instr = m_instr; n_ipc = m_ipc;
        n_halted = m_halted; n_mis = 0;
        if (redirect) begin
            n_pc     = redirect_pc & ~32'd3;
            n_valid  = 0;
            n_halted = 0;
            n_mis    = (redirect_pc % 4) != 0;
        end else if (!m_halted && (!m_valid || id_ready)) begin
            w = rom(m_pc);
            if (w != 0) begin
                n_instr = w; n_ipc = m_pc; n_valid = 1; n_pc = m_pc + 4;
            end else begin
                n_valid = 0; n_halted = 1;
            end
        end else if (took) begin
            n_valid = 0;
        end
        @(posedge clk);
        m_pc = n_pc; m_valid = n_valid; m_instr = n_instr; m_ipc = n_ipc;
        m_halted = n_halted; m_mis = n_mis; m_count = n_count;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [31:0] targets [8];
        targets = '{32'h0001_3880, 32'h0001_3886, 32'h0001_388C, 32'h0001_3893,
                    32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0001_3898, 32'h0000_0000};

        // Reset state
        rst_n = 0; id_ready = 1; redirect = 0; redirect_pc = 0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.addr_const", imem_addr, 32'h0001_3880);
        @(negedge clk);
        rst_n = 1;

        // First two fetches and latency
        tick("fetch1");
        check("fetch1.instr", if_instr, 32'h002B_1513);
        check("fetch1.pc",    if_pc,    32'h0001_3880);
        tick("fetch2");
        check("fetch2.instr", if_instr, 32'h0195_0533);
        check("fetch2.pc",    if_pc,    32'h0001_3884);
        tick("fetch3");

        // Stall for three cycles at 0x13888
        id_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.instr", if_instr,  32'h0003_4483);
            check("stall.addr",  imem_addr, 32'h0001_388C);
        end
        id_ready = 1;
        tick("release");
        check("release.pc", if_pc, 32'h0001_388C);

        // Run into the zero word
        tick("run1");
        tick("run2");
        check("run2.instr", if_instr, 32'hFE00_06E3);
        for (int i = 0; i < 4; i++) tick("halt");
        check("halt.flag", {31'b0, halted}, 32'd1);
        check("halt.pc",   imem_addr,       32'h0001_3898);

        // Redirect out of HALT
        redirect = 1; redirect_pc = 32'h0001_3880;
        tick("redir_halt");
        redirect = 0;
        check("redir_halt.halted", {31'b0, halted}, 32'd0);
        tick("redir_fetch");
        check("redir_fetch.instr", if_instr, 32'h002B_1513);
        tick("redir_fetch2");

        // Misaligned redirect while the stage is full
        redirect = 1; redirect_pc = 32'h0001_3886;
        tick("mis");
        redirect = 0;
        check("mis.pulse", {31'b0, misaligned}, 32'd1);
        check("mis.addr",  imem_addr,           32'h0001_3884);
        tick("mis_clear");
        check("mis_clear.pulse", {31'b0, misaligned}, 32'd0);

        // Asynchronous reset during a stall
        tick("pre_stall");
        id_ready = 0;
        tick("stall2");
        tick("stall3");
        #2 rst_n = 0;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1; id_ready = 1;
        tick("resume");
        check("resume.instr", if_instr, 32'h002B_1513);

        // Randomized traffic, including wrap at the top of the address space
        for (int i = 0; i < 400; i++) begin
            id_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 5) == 0) ? $urandom() : targets[$urandom_range(0, 7)];
            tick("rand");
        end
        redirect = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
